// File: rtl/bus_demux.sv
// Data-memory port distributor: routes CPU loads/stores to data memory or to a
// small MMIO bank holding an output mailbox, an input mailbox and a cycle counter.
module bus_demux #(
  parameter logic [31:0] MMIO_BASE = 32'h0000_7F00,
  parameter int          DMEM_AW   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        cpu_addr_i,
  input  logic               cpu_we_i,
  input  logic               cpu_re_i,
  input  logic [31:0]        cpu_wd_i,
  output logic [31:0]        cpu_rd_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic               dmem_we_o,
  output logic [31:0]        dmem_wd_o,
  input  logic [31:0]        dmem_rd_i,
  output logic               io_out_valid_o,
  output logic [31:0]        io_out_data_o,
  input  logic               io_out_ack_i,
  input  logic               io_in_valid_i,
  input  logic [31:0]        io_in_data_i,
  output logic [1:0]         overrun_o
);

  localparam logic [7:0] OFF_OUT_READY = 8'h00;
  localparam logic [7:0] OFF_OUT_DATA  = 8'h04;
  localparam logic [7:0] OFF_IN_VALID  = 8'h08;
  localparam logic [7:0] OFF_IN_DATA   = 8'h0C;
  localparam logic [7:0] OFF_STATUS    = 8'h10;
  localparam logic [7:0] OFF_CYCLE     = 8'h20;

  logic        selIo;
  logic [7:0]  offset;
  logic        wrOutData;
  logic        wrStatus;
  logic        rdInData;
  logic        outOverrun;
  logic        inOverrun;
  logic [1:0]  clearMask;
  logic [31:0] mmioRdata;

  logic        outValid_q, outValid_d;
  logic [31:0] outData_q,  outData_d;
  logic        inValid_q,  inValid_d;
  logic [31:0] inData_q,   inData_d;
  logic [1:0]  overrun_q,  overrun_d;
  logic [31:0] cycleCount_q, cycleCount_d;

  assign selIo  = (cpu_addr_i[31:8] == MMIO_BASE[31:8]);
  assign offset = cpu_addr_i[7:0];

  assign wrOutData = cpu_we_i & selIo & (offset == OFF_OUT_DATA);
  assign wrStatus  = cpu_we_i & selIo & (offset == OFF_STATUS);
  assign rdInData  = cpu_re_i & selIo & (offset == OFF_IN_DATA);

  assign dmem_addr_o = cpu_addr_i[DMEM_AW+1:2];
  assign dmem_we_o   = cpu_we_i & ~selIo;
  assign dmem_wd_o   = cpu_wd_i;

  // A store is accepted if the mailbox is empty or is being drained this same cycle.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outOverrun = 1'b0;
    if (wrOutData) begin
      if (!outValid_q || io_out_ack_i) begin
        outValid_d = 1'b1;
        outData_d  = cpu_wd_i;
      end else begin
        outOverrun = 1'b1;
      end
    end else if (io_out_ack_i) begin
      outValid_d = 1'b0;
    end
  end

  // A strobe coinciding with a consuming load is a clean hand-off, not an overrun.
  always_comb begin
    inValid_d = inValid_q;
    inData_d  = inData_q;
    inOverrun = 1'b0;
    if (io_in_valid_i) begin
      inValid_d = 1'b1;
      inData_d  = io_in_data_i;
      inOverrun = inValid_q & ~rdInData;
    end else if (rdInData) begin
      inValid_d = 1'b0;
    end
  end

  always_comb begin
    clearMask    = wrStatus ? cpu_wd_i[1:0] : 2'b00;
    overrun_d    = (overrun_q & ~clearMask) | {inOverrun, outOverrun};
    cycleCount_d = cycleCount_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outValid_q   <= 1'b0;
      outData_q    <= 32'd0;
      inValid_q    <= 1'b0;
      inData_q     <= 32'd0;
      overrun_q    <= 2'b00;
      cycleCount_q <= 32'd0;
    end else begin
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      inValid_q    <= inValid_d;
      inData_q     <= inData_d;
      overrun_q    <= overrun_d;
      cycleCount_q <= cycleCount_d;
    end
  end

  always_comb begin
    mmioRdata = 32'd0;
    case (offset)
      OFF_OUT_READY: mmioRdata = {31'd0, ~outValid_q};
      OFF_IN_VALID:  mmioRdata = {31'd0, inValid_q};
      OFF_IN_DATA:   mmioRdata = inData_q;
      OFF_STATUS:    mmioRdata = {30'd0, overrun_q};
      OFF_CYCLE:     mmioRdata = cycleCount_q;
      default:       mmioRdata = 32'd0;
    endcase
  end

  assign cpu_rd_o       = selIo ? mmioRdata : dmem_rd_i;
  assign io_out_valid_o = outValid_q;
  assign io_out_data_o  = outData_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_bus_demux.sv
// Self-checking bench for bus_demux: directed vector table, hand sequences for
// counter wrap and mid-handshake reset, then random traffic against a model.
module tb_bus_demux;

  localparam logic [31:0] MMIO_BASE = 32'h0000_7F00;
  localparam int          DMEM_AW   = 8;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        cpuAddr;
  logic               cpuWe;
  logic               cpuRe;
  logic [31:0]        cpuWd;
  logic [31:0]        cpuRd;
  logic [DMEM_AW-1:0] dmemAddr;
  logic               dmemWe;
  logic [31:0]        dmemWd;
  logic [31:0]        dmemRd;
  logic               ioOutValid;
  logic [31:0]        ioOutData;
  logic               ioOutAck;
  logic               ioInValid;
  logic [31:0]        ioInData;
  logic [1:0]         overrun;

  int checks = 0;
  int errors = 0;

  // Behavioural model state, updated at every rising edge from the driven inputs.
  logic        mOutValid;
  logic [31:0] mOutData;
  logic        mInValid;
  logic [31:0] mInData;
  logic [1:0]  mOverrun;
  logic [31:0] mCycle;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    bit          re;
    logic [31:0] wd;
    logic [31:0] dmemRd;
    bit          ack;
    bit          inV;
    logic [31:0] inD;
    logic [31:0] expRd;
    bit          expDWe;
    bit          expOV;
    logic [31:0] expOD;
    logic [1:0]  expOvr;
  } vec_t;

  vec_t vecs[$];

  bus_demux #(.MMIO_BASE(MMIO_BASE), .DMEM_AW(DMEM_AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_addr_i    (cpuAddr),
    .cpu_we_i      (cpuWe),
    .cpu_re_i      (cpuRe),
    .cpu_wd_i      (cpuWd),
    .cpu_rd_o      (cpuRd),
    .dmem_addr_o   (dmemAddr),
    .dmem_we_o     (dmemWe),
    .dmem_wd_o     (dmemWd),
    .dmem_rd_i     (dmemRd),
    .io_out_valid_o(ioOutValid),
    .io_out_data_o (ioOutData),
    .io_out_ack_i  (ioOutAck),
    .io_in_valid_i (ioInValid),
    .io_in_data_i  (ioInData),
    .overrun_o     (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [31:0] a, input bit w, input bit re,
                               input logic [31:0] wd, input logic [31:0] dr, input bit ack,
                               input bit iv, input logic [31:0] id);
    @(negedge clk);
    rst = r; cpuAddr = a; cpuWe = w; cpuRe = re; cpuWd = wd;
    dmemRd = dr; ioOutAck = ack; ioInValid = iv; ioInData = id;
    #1;
  endtask

  function automatic bit modelSel(input logic [31:0] a);
    return (a / 256) == (MMIO_BASE / 256);
  endfunction

  function automatic logic [31:0] modelRead();
    if (!modelSel(cpuAddr)) return dmemRd;
    case (cpuAddr % 256)
      32'h00:  return mOutValid ? 32'd0 : 32'd1;
      32'h08:  return mInValid ? 32'd1 : 32'd0;
      32'h0C:  return mInData;
      32'h10:  return {30'd0, mOverrun};
      32'h20:  return mCycle;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock and apply the mailbox rules to the model.
  task automatic advance();
    bit storeOut, storeStatus, loadIn;
    logic [1:0] nextOvr;
    @(posedge clk);
    storeOut    = cpuWe && modelSel(cpuAddr) && (cpuAddr % 256 == 32'h04);
    storeStatus = cpuWe && modelSel(cpuAddr) && (cpuAddr % 256 == 32'h10);
    loadIn      = cpuRe && modelSel(cpuAddr) && (cpuAddr % 256 == 32'h0C);
    if (rst) begin
      mOutValid = 1'b0; mOutData = 32'd0; mInValid = 1'b0;
      mInData = 32'd0; mOverrun = 2'b00; mCycle = 32'd0;
    end else begin
      nextOvr = mOverrun;
      if (storeStatus) nextOvr = nextOvr & ~cpuWd[1:0];
      if (storeOut && mOutValid && !ioOutAck) nextOvr[0] = 1'b1;
      else if (storeOut) begin mOutValid = 1'b1; mOutData = cpuWd; end
      else if (ioOutAck) mOutValid = 1'b0;
      if (ioInValid) begin
        if (mInValid && !loadIn) nextOvr[1] = 1'b1;
        mInValid = 1'b1; mInData = ioInData;
      end else if (loadIn) mInValid = 1'b0;
      mOverrun = nextOvr;
      mCycle = mCycle + 32'd1;
    end
  endtask

  task automatic checkAgainstModel(input int idx);
    checkOutput($sformatf("rnd%0d cpu_rd", idx), cpuRd, modelRead());
    checkOutput($sformatf("rnd%0d dmem_we", idx), {31'd0, dmemWe},
                {31'd0, cpuWe && !modelSel(cpuAddr)});
    checkOutput($sformatf("rnd%0d dmem_addr", idx), {24'd0, dmemAddr}, (cpuAddr / 4) % 256);
    checkOutput($sformatf("rnd%0d dmem_wd", idx), dmemWd, cpuWd);
    checkOutput($sformatf("rnd%0d out_valid", idx), {31'd0, ioOutValid}, {31'd0, mOutValid});
    checkOutput($sformatf("rnd%0d out_data", idx), ioOutData, mOutData);
    checkOutput($sformatf("rnd%0d overrun", idx), {30'd0, overrun}, {30'd0, mOverrun});
  endtask

  function automatic void addVec(input logic [31:0] a, input bit w, input bit r, input logic [31:0] wd,
                                 input logic [31:0] dr, input bit ack, input bit iv, input logic [31:0] id,
                                 input logic [31:0] er, input bit edwe, input bit eov,
                                 input logic [31:0] eod, input logic [1:0] eovr);
    vec_t v;
    v.addr = a; v.we = w; v.re = r; v.wd = wd; v.dmemRd = dr; v.ack = ack; v.inV = iv; v.inD = id;
    v.expRd = er; v.expDWe = edwe; v.expOV = eov; v.expOD = eod; v.expOvr = eovr;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] offs [8];
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h14, 32'h01};

    // Expected values are the state seen before each vector's clock edge.
    addVec(32'h10,   T, F, 32'hDEADBEEF, 32'h0,  F, F, 32'h0,  32'h0,        T, F, 32'h0,        2'd0);
    addVec(32'h10,   F, T, 32'h0, 32'hDEADBEEF,  F, F, 32'h0,  32'hDEADBEEF, F, F, 32'h0,        2'd0);
    addVec(32'h7F00, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h1,        F, F, 32'h0,        2'd0);
    addVec(32'h7F04, T, F, 32'h12345678, JUNK,   F, F, 32'h0,  32'h0,        F, F, 32'h0,        2'd0);
    addVec(32'h7F00, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h0,        F, T, 32'h12345678, 2'd0);
    addVec(32'h7F00, F, T, 32'h0,        JUNK,   T, F, 32'h0,  32'h0,        F, T, 32'h12345678, 2'd0);
    addVec(32'h7F00, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h1,        F, F, 32'h12345678, 2'd0);
    addVec(32'h7F04, T, F, 32'hA,        JUNK,   F, F, 32'h0,  32'h0,        F, F, 32'h12345678, 2'd0);
    addVec(32'h7F04, T, F, 32'hB,        JUNK,   F, F, 32'h0,  32'h0,        F, T, 32'hA,        2'd0);
    addVec(32'h7F10, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h1,        F, T, 32'hA,        2'd1);
    addVec(32'h7F10, T, F, 32'h1,        JUNK,   F, F, 32'h0,  32'h1,        F, T, 32'hA,        2'd1);
    addVec(32'h7F10, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h0,        F, T, 32'hA,        2'd0);
    addVec(32'h7F00, F, T, 32'h0,        JUNK,   T, F, 32'h0,  32'h0,        F, T, 32'hA,        2'd0);
    addVec(32'h7F08, F, T, 32'h0,        JUNK,   F, T, 32'h55, 32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F08, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h1,        F, F, 32'hA,        2'd0);
    addVec(32'h7F0C, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h55,       F, F, 32'hA,        2'd0);
    addVec(32'h7F08, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F08, F, T, 32'h0,        JUNK,   F, T, 32'h55, 32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F0C, F, T, 32'h0,        JUNK,   F, T, 32'h66, 32'h55,       F, F, 32'hA,        2'd0);
    addVec(32'h7F08, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h1,        F, F, 32'hA,        2'd0);
    addVec(32'h7F10, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F0C, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h66,       F, F, 32'hA,        2'd0);
    addVec(32'h7F08, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F08, F, F, 32'h0,        JUNK,   F, T, 32'h1,  32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F08, F, F, 32'h0,        JUNK,   F, T, 32'h2,  32'h1,        F, F, 32'hA,        2'd0);
    addVec(32'h7F0C, F, F, 32'h0,        JUNK,   F, F, 32'h0,  32'h2,        F, F, 32'hA,        2'd2);
    addVec(32'h7F10, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h2,        F, F, 32'hA,        2'd2);
    addVec(32'h7F10, T, T, 32'h2,        JUNK,   F, F, 32'h0,  32'h2,        F, F, 32'hA,        2'd2);
    addVec(32'h7F10, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F14, T, T, 32'hFFFFFFFF, JUNK,   F, F, 32'h0,  32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F01, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'h0,        F, F, 32'hA,        2'd0);
    addVec(32'h7F20, F, T, 32'h0,        JUNK,   F, F, 32'h0,  32'd31,       F, F, 32'hA,        2'd0);

    applyStimulus(T, 32'h0, F, F, 32'h0, JUNK, F, F, 32'h0);
    advance();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(F, vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].wd, vecs[i].dmemRd,
                    vecs[i].ack, vecs[i].inV, vecs[i].inD);
      checkOutput($sformatf("vec%0d cpu_rd", i), cpuRd, vecs[i].expRd);
      checkOutput($sformatf("vec%0d dmem_we", i), {31'd0, dmemWe}, {31'd0, vecs[i].expDWe});
      checkOutput($sformatf("vec%0d dmem_addr", i), {24'd0, dmemAddr}, {24'd0, vecs[i].addr[9:2]});
      checkOutput($sformatf("vec%0d out_valid", i), {31'd0, ioOutValid}, {31'd0, vecs[i].expOV});
      checkOutput($sformatf("vec%0d out_data", i), ioOutData, vecs[i].expOD);
      checkOutput($sformatf("vec%0d overrun", i), {30'd0, overrun}, {30'd0, vecs[i].expOvr});
      advance();
    end

    // Counter wrap: preload the counter with its maximum value.
    applyStimulus(F, 32'h7F20, F, T, 32'h0, JUNK, F, F, 32'h0);
    force dut.cycleCount_q = 32'hFFFF_FFFF;
    #1;
    checkOutput("cycle forced", cpuRd, 32'hFFFF_FFFF);
    release dut.cycleCount_q;
    mCycle = 32'hFFFF_FFFF;
    advance();
    applyStimulus(F, 32'h7F20, F, T, 32'h0, JUNK, F, F, 32'h0);
    checkOutput("cycle wrap", cpuRd, 32'h0);
    advance();

    // Reset while the output mailbox is full and an overrun is flagged.
    applyStimulus(F, 32'h7F04, T, F, 32'h77, JUNK, F, F, 32'h0);
    advance();
    applyStimulus(F, 32'h7F04, T, F, 32'h88, JUNK, F, F, 32'h0);
    checkOutput("pre-rst out_valid", {31'd0, ioOutValid}, 32'h1);
    checkOutput("pre-rst out_data", ioOutData, 32'h77);
    advance();
    applyStimulus(T, 32'h7F00, F, F, 32'h0, JUNK, F, F, 32'h0);
    checkOutput("pre-rst overrun", {30'd0, overrun}, 32'h1);
    advance();
    applyStimulus(F, 32'h7F20, F, T, 32'h0, JUNK, F, F, 32'h0);
    checkOutput("post-rst out_valid", {31'd0, ioOutValid}, 32'h0);
    checkOutput("post-rst out_data", ioOutData, 32'h0);
    checkOutput("post-rst overrun", {30'd0, overrun}, 32'h0);
    checkOutput("post-rst cycle", cpuRd, 32'h0);
    advance();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 8) a = MMIO_BASE + offs[pick];
      else if (pick == 8) a = $urandom;
      else a = $urandom & 32'h0000_03FF;
      applyStimulus(($urandom_range(0, 63) == 0), a, bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
      checkAgainstModel(i);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_demux.md
Name: bus_demux

Overview:
- Address decoder/distributor on the CPU data-memory port. It is the fan-out counterpart to the write-back/read selectors.
- Routes each CPU load/store either to the data memory or to a small MMIO register bank.
- The MMIO bank holds an output mailbox (CPU to peripheral), an input mailbox (peripheral to CPU) and a free-running cycle counter.
- Sits between the MEM stage and the data memory / I/O board logic.

Parameters:
- MMIO_BASE, 32'h0000_7F00, base byte address of the MMIO window; the window is 256 bytes (addr[31:8] == MMIO_BASE[31:8]).
- DMEM_AW, 8, data-memory word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_addr  in  32  byte address from the MEM stage.
- cpu_we  in  1  store strobe.
- cpu_re  in  1  load strobe.
- cpu_wd  in  32  store data.
- cpu_rd  out  32  load data (combinational).
- dmem_addr  out  DMEM_AW  word address, equal to cpu_addr[DMEM_AW+1:2].
- dmem_we  out  1  data-memory write enable.
- dmem_wd  out  32  equal to cpu_wd.
- dmem_rd  in  32  data-memory asynchronous read data.
- io_out_valid  out  1  output mailbox holds data.
- io_out_data  out  32  output mailbox contents.
- io_out_ack  in  1  peripheral consumed the output word.
- io_in_valid  in  1  single-cycle strobe: new input word.
- io_in_data  in  32  input word.
- overrun  out  2  sticky flags: bit0 output overrun, bit1 input overrun.

Behaviour:
- sel_io = (cpu_addr[31:8] == MMIO_BASE[31:8]).
- dmem_we = cpu_we & ~sel_io.
- cpu_rd = sel_io ? mmio_rdata : dmem_rd, combinational, 0-cycle latency.
- MMIO map (offset = cpu_addr[7:0]; word aligned; any other offset reads 0 and ignores writes):
  - 0x00 OUT_READY (R): {31'b0, ~out_valid}.
  - 0x04 OUT_DATA (W): store loads the mailbox and sets out_valid next edge.
  - 0x08 IN_VALID (R): {31'b0, in_valid}.
  - 0x0C IN_DATA (R): returns in_data. A load with cpu_re=1 clears in_valid next edge.
  - 0x10 STATUS (R/W): read {30'b0, overrun}; a store writes 1-to-clear on bits [1:0].
  - 0x20 CYCLE (R): 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF to 0.
- Output mailbox:
  - io_out_valid = out_valid; io_out_data = registered mailbox value.
  - io_out_ack while out_valid=1 clears out_valid next edge; io_out_ack while out_valid=0 is ignored.
  - Store to OUT_DATA while out_valid=1 and no ack in the same cycle: data dropped, mailbox unchanged, overrun[0] set.
  - Store to OUT_DATA with out_valid=1 and io_out_ack=1 in the same cycle: accepted, new data latched, out_valid stays 1.
- Input mailbox:
  - io_in_valid latches io_in_data and sets in_valid next edge.
  - io_in_valid while in_valid=1 and no consuming IN_DATA load that cycle: new word overwrites, overrun[1] set.
  - io_in_valid in the same cycle as a consuming IN_DATA load: CPU reads the old word, new word latched, in_valid stays 1, no overrun.
- STATUS clear vs new overrun in the same cycle: set wins.
- cpu_we and cpu_re both asserted: the store takes effect; the load still returns pre-edge data.
- Loads from DMEM or other offsets have no side effects.
- Reset (synchronous, on any cycle including mid-handshake): out_valid=0, mailbox=0, in_valid=0, in_data=0, overrun=0, cycle=0.
  - Therefore io_out_valid=0, io_out_data=0, overrun=0 after reset.
  - cpu_rd and the dmem_* outputs remain combinational functions of their inputs.

Test Plan:
- DMEM routing: store 0xDEADBEEF to 0x0000_0010 -> dmem_we=1, dmem_addr=4, no MMIO change. Load 0x10 with dmem_rd=0xDEADBEEF -> cpu_rd=0xDEADBEEF.
- Output handshake: store 0x12345678 to 0x7F04 -> next cycle io_out_valid=1, io_out_data=0x12345678, OUT_READY reads 0. Pulse io_out_ack -> io_out_valid=0, OUT_READY reads 1.
- Output overrun: two stores (0xA, then 0xB) to 0x7F04 with no ack -> io_out_data=0xA, STATUS reads 1. Store 1 to 0x7F10 -> STATUS reads 0.
- Input path and collision: io_in_valid with 0x55 -> IN_VALID reads 1, IN_DATA load returns 0x55, then IN_VALID reads 0. Second word 0x66 arriving in the same cycle as an IN_DATA load of 0x55 -> load returns 0x55, in_valid stays 1, next IN_DATA load returns 0x66, overrun stays 0.
- Input overrun: two io_in_valid strobes (0x1, 0x2) without a read -> IN_DATA=0x2, STATUS=2.
- Counter and reset: after rst deassert, CYCLE read N cycles later = N. Force counter to 0xFFFF_FFFF -> next read 0. Assert rst while io_out_valid=1 -> io_out_valid=0 and overrun=0 the next cycle.
